// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles the three buses seen by the memory arbiter:
//   if_*  instruction-fetch requester (read-only, word accesses)
//   ls_*  load/store requester (byte/half/word/double, read or write)
//   m_*   single-ported memory (strobe cycle, response the cycle after)
//
// Modports:
//   slave  - the arbiter: consumes requests and memory responses, produces
//            requester responses and memory strobes.
//   master - the environment: requesters plus the memory itself.
// ---------------------------------------------------------------------------
interface mem_arbiter_if;

  // Instruction-fetch requester
  logic        if_req;
  logic [63:0] if_addr;
  logic [63:0] if_rdata;
  logic        if_ready;
  logic        if_exception;

  // Load/store requester
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_size;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [63:0] ls_rdata;
  logic        ls_ready;
  logic        ls_exception;

  // Memory side
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_size;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_exception;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready, if_exception,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output ls_rdata, ls_ready, ls_exception,
    output m_read, m_write, m_size, m_addr, m_wdata,
    input  m_rdata, m_exception
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready, if_exception,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  ls_rdata, ls_ready, ls_exception,
    input  m_read, m_write, m_size, m_addr, m_wdata,
    output m_rdata, m_exception
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between an instruction-fetch requester (IF) and a
// load/store requester (LS). Each access takes three cycles:
//   IDLE  - arbitrate and capture the winner's address/size/we/wdata
//   ISSUE - drive the captured fields on m_* for exactly one cycle
//   RESP  - forward m_rdata/m_exception with a one-cycle ready pulse
//
// LS normally wins a tie; after four consecutive LS grants taken while IF
// was also waiting, IF gets the next tie so it cannot be starved.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_arbiter_if.slave (requester and memory buses)
// ---------------------------------------------------------------------------
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_IF,
    ISSUE_LS,
    RESP_IF,
    RESP_LS
  } state_e;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [2:0] STREAK_MAX = 3'd4;

  state_e      state_q, state_d;
  logic [2:0]  streak_q, streak_d;   // consecutive LS wins over a waiting IF
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;

  // Arbitration is only meaningful in IDLE; the next-state logic ignores
  // these signals in every other state.
  logic if_starved;
  logic grant_ls;
  logic grant_if;

  assign if_starved = bus.if_req && (streak_q == STREAK_MAX);
  assign grant_ls   = bus.ls_req && !if_starved;
  assign grant_if   = bus.if_req && !grant_ls;

  // -------------------------------------------------------------------------
  // State and captured request fields
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      we_q     <= we_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    we_d     = we_q;

    unique case (state_q)
      IDLE: begin
        if (grant_ls) begin
          state_d = ISSUE_LS;
          addr_d  = bus.ls_addr;
          wdata_d = bus.ls_wdata;
          size_d  = bus.ls_size;
          we_d    = bus.ls_we;
          // The streak only grows while IF is actually being made to wait.
          if (bus.if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX
                                                : streak_q + 3'd1;
          end else begin
            streak_d = '0;
          end
        end else if (grant_if) begin
          state_d  = ISSUE_IF;
          addr_d   = bus.if_addr;
          wdata_d  = '0;
          size_d   = SIZE_WORD;
          we_d     = 1'b0;
          streak_d = '0;
        end
      end
      ISSUE_IF: state_d = RESP_IF;
      ISSUE_LS: state_d = RESP_LS;
      RESP_IF:  state_d = IDLE;
      RESP_LS:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from the registered state only, and forced to zero in
  // any cycle with rst high so an aborted access never strobes memory or
  // pulses ready.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.m_read       = 1'b0;
    bus.m_write      = 1'b0;
    bus.m_size       = '0;
    bus.m_addr       = '0;
    bus.m_wdata      = '0;
    bus.if_ready     = 1'b0;
    bus.if_exception = 1'b0;
    bus.if_rdata     = '0;
    bus.ls_ready     = 1'b0;
    bus.ls_exception = 1'b0;
    bus.ls_rdata     = '0;

    if (!rst) begin
      unique case (state_q)
        ISSUE_IF: begin
          bus.m_read = 1'b1;
          bus.m_size = size_q;
          bus.m_addr = addr_q;
        end
        ISSUE_LS: begin
          bus.m_read  = !we_q;
          bus.m_write = we_q;
          bus.m_size  = size_q;
          bus.m_addr  = addr_q;
          bus.m_wdata = wdata_q;
        end
        RESP_IF: begin
          bus.if_ready     = 1'b1;
          bus.if_exception = bus.m_exception;
          bus.if_rdata     = bus.m_rdata;
        end
        RESP_LS: begin
          bus.ls_ready     = 1'b1;
          bus.ls_exception = bus.m_exception;
          // A store returns no data even if memory drives something.
          bus.ls_rdata     = we_q ? '0 : bus.m_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small 256-entry memory model answers the
// m_* strobes one cycle later; unwritten locations read back as
// 64'hD000_0000_0000_0000 | addr so load data is predictable by hand.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit fault_en = 1'b0;

  localparam logic [63:0] DFLT = 64'hD000_0000_0000_0000;

  // -------------------------------------------------------------------------
  // Memory model
  // -------------------------------------------------------------------------
  logic [63:0] mem [0:255];

  function automatic logic [63:0] size_mask(input logic [2:0] sz);
    case (sz)
      3'b000:  return 64'h0000_0000_0000_00FF;
      3'b001:  return 64'h0000_0000_0000_FFFF;
      3'b010:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DFLT | 64'(i);
  end

  always @(posedge clk) begin
    if (bus.m_write) mem[bus.m_addr[7:0]] <= bus.m_wdata & size_mask(bus.m_size);
    if (bus.m_read) bus.m_rdata <= mem[bus.m_addr[7:0]];
    else            bus.m_rdata <= '0;
    bus.m_exception <= fault_en & (bus.m_read | bus.m_write);
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Strobe and ready exclusivity hold in every cycle once reset has settled.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_wr_excl", bus.m_read & bus.m_write, 1'b0);
      check("ready_excl", bus.if_ready & bus.ls_ready, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the selected ready pulses, up to budget cycles.
  task automatic wait_ready(input bit is_ls, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(is_ls ? bus.ls_ready : bus.if_ready) && cycles < budget);
  endtask

  task automatic ls_drive(input bit we, input logic [2:0] sz,
                          input logic [63:0] addr, input logic [63:0] wd);
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_size  = sz;
    bus.ls_addr  = addr;
    bus.ls_wdata = wd;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int         n;
    int         g;
    logic [5:0] order;

    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_size  = '0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    // Requests raised during reset must be ignored.
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'd100;

    repeat (2) tick();
    check("rst_m_read",   bus.m_read,   1'b0);
    check("rst_m_addr",   bus.m_addr,   64'd0);
    check("rst_if_ready", bus.if_ready, 1'b0);
    check("rst_ls_ready", bus.ls_ready, 1'b0);
    bus.if_req = 1'b0;
    rst        = 1'b0;
    mon_en     = 1'b1;
    tick();
    check("idle_m_read",  bus.m_read,  1'b0);
    check("idle_m_write", bus.m_write, 1'b0);

    // ---- Byte store then double load at address 0 ----
    ls_drive(1'b1, 3'b000, 64'd0, 64'hA5);
    tick();                                   // ISSUE_LS
    check("st_m_write", bus.m_write, 1'b1);
    check("st_m_read",  bus.m_read,  1'b0);
    check("st_m_addr",  bus.m_addr,  64'd0);
    check("st_m_wdata", bus.m_wdata, 64'hA5);
    check("st_m_size",  bus.m_size,  3'b000);
    check("st_early_rdy", bus.ls_ready, 1'b0);
    tick();                                   // RESP_LS
    check("st_ready", bus.ls_ready, 1'b1);
    check("st_rdata", bus.ls_rdata, 64'd0);
    check("st_m_write_off", bus.m_write, 1'b0);
    bus.ls_req = 1'b0;
    tick();                                   // IDLE
    check("st_ready_drop", bus.ls_ready, 1'b0);

    ls_drive(1'b0, 3'b011, 64'd0, 64'd0);
    tick();
    check("ld_m_read", bus.m_read, 1'b1);
    tick();
    check("ld_ready", bus.ls_ready, 1'b1);
    check("ld_rdata", bus.ls_rdata, 64'hA5);
    check("ld_exc",   bus.ls_exception, 1'b0);
    bus.ls_req = 1'b0;
    tick();

    // ---- Simultaneous IF and LS: LS first, IF three cycles later ----
    bus.if_req  = 1'b1;
    bus.if_addr = 64'd100;
    ls_drive(1'b0, 3'b011, 64'd8, 64'd0);
    tick();
    check("tie_m_addr", bus.m_addr, 64'd8);
    tick();
    check("tie_ls_ready", bus.ls_ready, 1'b1);
    check("tie_ls_rdata", bus.ls_rdata, DFLT | 64'd8);
    bus.ls_req = 1'b0;
    wait_ready(1'b0, 6, n);
    check("tie_if_gap",   n, 3);
    check("tie_if_rdata", bus.if_rdata, DFLT | 64'd100);
    check("tie_if_exc",   bus.if_exception, 1'b0);
    bus.if_req = 1'b0;
    tick();

    // ---- Starvation guard: both held, order LS LS LS LS IF LS ----
    bus.if_req = 1'b1;
    ls_drive(1'b0, 3'b011, 64'd8, 64'd0);
    g     = 0;
    order = '0;
    for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
      tick();
      if (bus.ls_ready) begin
        order[g] = 1'b0;
        g++;
      end else if (bus.if_ready) begin
        order[g] = 1'b1;
        g++;
      end
    end
    check("starve_count", g, 6);
    check("starve_order", order, 6'b010000);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    tick();

    // ---- Fault passthrough on a word load ----
    fault_en = 1'b1;
    ls_drive(1'b0, 3'b010, 64'd5, 64'd0);
    tick();
    check("flt_m_size", bus.m_size, 3'b010);
    tick();
    check("flt_ready", bus.ls_ready, 1'b1);
    check("flt_exc",   bus.ls_exception, 1'b1);
    check("flt_rdata", bus.ls_rdata, DFLT | 64'd5);
    check("flt_if_exc", bus.if_exception, 1'b0);
    bus.ls_req = 1'b0;
    fault_en   = 1'b0;
    tick();

    // ---- Reset during ISSUE_LS of a store ----
    ls_drive(1'b1, 3'b011, 64'h40, 64'h1234);
    tick();                                   // ISSUE_LS
    check("rma_pre_write", bus.m_write, 1'b1);
    rst = 1'b1;
    #1;
    check("rma_m_write", bus.m_write, 1'b0);
    check("rma_m_addr",  bus.m_addr,  64'd0);
    check("rma_m_wdata", bus.m_wdata, 64'd0);
    // Request held across reset, now a load of the aborted store's address.
    ls_drive(1'b0, 3'b011, 64'h40, 64'd0);
    tick();                                   // reset edge
    check("rma_no_ready", bus.ls_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rma_idle_ready", bus.ls_ready, 1'b0);
    check("rma_idle_read",  bus.m_read,   1'b0);
    tick();
    check("rma_post_read", bus.m_read, 1'b1);
    check("rma_post_addr", bus.m_addr, 64'h40);
    tick();
    check("rma_post_ready", bus.ls_ready, 1'b1);
    check("rma_not_stored", bus.ls_rdata, DFLT | 64'h40);
    bus.ls_req = 1'b0;
    tick();

    // ---- Field change after grant, then back-to-back re-request ----
    ls_drive(1'b0, 3'b011, 64'd10, 64'd0);
    tick();                                   // ISSUE_LS
    bus.ls_addr = 64'd20;
    #1;
    check("fld_m_addr", bus.m_addr, 64'd10);
    tick();
    check("fld_rdata", bus.ls_rdata, DFLT | 64'd10);
    tick();                                   // IDLE, request still high
    check("b2b_idle_ready", bus.ls_ready, 1'b0);
    tick();
    check("b2b_m_addr", bus.m_addr, 64'd20);
    tick();
    check("b2b_ready", bus.ls_ready, 1'b1);
    bus.ls_req = 1'b0;
    tick();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
